// File: rtl/sram_host_ctrl_pkg.sv
// Shared encoding for the SRAM host controller: FSM states, opcodes and word geometry.
package sram_ctrl_pkg;
  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 32;
  localparam int NBYTES     = DATA_W_DEF / 8;

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam int         DPU_FLAG = 7;

  typedef enum logic [3:0] {
    IDLE,
    WR_COL,
    WR_MEM,
    RD_MEM,
    RD_CAP,
    RD_SEND,
    DPU_START,
    DPU_FEED,
    DPU_CAL,
    DPU_WB
  } state_t;
endpackage

// File: rtl/sram_host_ctrl_if.sv
// Pin-level byte interface: command/data bytes in, read-data bytes out.
interface sram_host_ctrl_if;
  logic [7:0] cmd_in;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_ready;

  modport slave (
    input  cmd_in, cmd_valid, dout_ready,
    output cmd_ready, dout, dout_valid
  );

  modport master (
    output cmd_in, cmd_valid, dout_ready,
    input  cmd_ready, dout, dout_valid
  );
endinterface

// File: rtl/sram_host_ctrl_byte_word_pack.sv
// LSB-first byte/word packer: assembles write words and serialises read words
// through one shift register and a shared byte counter.
module byte_word_pack
  import sram_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              shift_in,
  input  logic              load,
  input  logic              shift_out,
  input  logic [7:0]        byte_in,
  input  logic [DATA_W-1:0] load_word,
  output logic [DATA_W-1:0] word,
  output logic              last
);
  logic [1:0] cnt;

  assign last = (cnt == 2'(NBYTES - 1));

  // Both directions shift right, so byte 0 always sits in word[7:0].
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word <= '0;
      cnt  <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (load) begin
      word <= load_word;
      cnt  <= '0;
    end else if (shift_in) begin
      word <= {byte_in, word[DATA_W-1:8]};
      cnt  <= cnt + 2'd1;
    end else if (shift_out) begin
      word <= {8'h00, word[DATA_W-1:8]};
      cnt  <= cnt + 2'd1;
    end
  end
endmodule

// File: rtl/sram_host_ctrl.sv
// Command front-end and SRAM sequencer: byte-wide word write/read plus the
// fixed load/feed/compute/write-back schedule for the downstream dpu.
module sram_host_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  sram_host_ctrl_if.slave      host,
  output logic                 busy,
  output logic                 sram_en,
  output logic                 sram_we,
  output logic [ADDR_W-1:0]    sram_addr,
  output logic [DATA_W-1:0]    sram_wdata,
  input  logic [DATA_W-1:0]    sram_rdata,
  output logic                 dpu_load_cmd,
  output logic                 requst_valid,
  output logic [7:0]           nxt_cmd,
  input  logic [DATA_W-1:0]    dpu_result
);
  state_t            state;
  logic [7:0]        cmd_q;
  logic [DATA_W-1:0] word;
  logic              pk_last;
  logic              accept;
  logic [1:0]        op;

  assign accept  = host.cmd_valid & host.cmd_ready;
  assign op      = host.cmd_in[6:5];
  assign nxt_cmd = cmd_q;
  assign host.dout = word[7:0];
  // dpu_result is registered by the dpu on the edge entering DPU_WB, so it is muxed, not latched.
  assign sram_wdata = (state == DPU_WB) ? dpu_result : word;

  byte_word_pack #(.DATA_W(DATA_W)) u_pack (
    .clk       (clk),
    .rst       (rst),
    .clear     ((state == IDLE) & accept),
    .shift_in  ((state == WR_COL) & host.cmd_valid),
    .load      (state == RD_CAP),
    .shift_out ((state == RD_SEND) & host.dout_ready),
    .byte_in   (host.cmd_in),
    .load_word (sram_rdata),
    .word      (word),
    .last      (pk_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      cmd_q           <= '0;
      host.cmd_ready  <= 1'b0;
      host.dout_valid <= 1'b0;
      busy            <= 1'b0;
      sram_en         <= 1'b0;
      sram_we         <= 1'b0;
      sram_addr       <= '0;
      dpu_load_cmd    <= 1'b0;
      requst_valid    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          host.cmd_ready <= 1'b1;
          if (accept) begin
            cmd_q     <= host.cmd_in;
            sram_addr <= host.cmd_in[ADDR_W-1:0];
            if (host.cmd_in[DPU_FLAG]) begin
              state          <= DPU_START;
              host.cmd_ready <= 1'b0;
              busy           <= 1'b1;
              dpu_load_cmd   <= 1'b1;
              sram_en        <= 1'b1;
              sram_we        <= 1'b0;
            end else if (op == OP_WRITE) begin
              state <= WR_COL;
              busy  <= 1'b1;
            end else if (op == OP_READ) begin
              state          <= RD_MEM;
              host.cmd_ready <= 1'b0;
              busy           <= 1'b1;
              sram_en        <= 1'b1;
              sram_we        <= 1'b0;
            end
          end
        end
        WR_COL: begin
          if (host.cmd_valid && pk_last) begin
            state          <= WR_MEM;
            host.cmd_ready <= 1'b0;
            sram_en        <= 1'b1;
            sram_we        <= 1'b1;
          end
        end
        WR_MEM: begin
          state          <= IDLE;
          sram_en        <= 1'b0;
          sram_we        <= 1'b0;
          host.cmd_ready <= 1'b1;
          busy           <= 1'b0;
        end
        RD_MEM: begin
          state   <= RD_CAP;
          sram_en <= 1'b0;
        end
        RD_CAP: begin
          state           <= RD_SEND;
          host.dout_valid <= 1'b1;
        end
        RD_SEND: begin
          if (host.dout_ready && pk_last) begin
            state           <= IDLE;
            host.dout_valid <= 1'b0;
            host.cmd_ready  <= 1'b1;
            busy            <= 1'b0;
          end
        end
        DPU_START: begin
          state        <= DPU_FEED;
          dpu_load_cmd <= 1'b0;
          sram_en      <= 1'b0;
          requst_valid <= 1'b1;
        end
        DPU_FEED: begin
          state        <= DPU_CAL;
          requst_valid <= 1'b0;
        end
        DPU_CAL: begin
          state        <= DPU_WB;
          requst_valid <= 1'b1;
          sram_en      <= 1'b1;
          sram_we      <= 1'b1;
        end
        DPU_WB: begin
          state          <= IDLE;
          requst_valid   <= 1'b0;
          sram_en        <= 1'b0;
          sram_we        <= 1'b0;
          host.cmd_ready <= 1'b1;
          busy           <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sram_host_ctrl.sv
// Bench for sram_host_ctrl: SRAM and dpu stand-ins, a word-level reference memory,
// and a per-cycle compare process on SRAM writes and read-byte handshakes.
module tb_sram_host_ctrl;
  logic        clk;
  logic        rst;
  logic        busy, sram_en, sram_we, dpu_load_cmd, requst_valid;
  logic [4:0]  sram_addr;
  logic [31:0] sram_wdata, sram_rdata, dpu_result;
  logic [7:0]  nxt_cmd;

  sram_host_ctrl_if h();

  sram_host_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .host         (h),
    .busy         (busy),
    .sram_en      (sram_en),
    .sram_we      (sram_we),
    .sram_addr    (sram_addr),
    .sram_wdata   (sram_wdata),
    .sram_rdata   (sram_rdata),
    .dpu_load_cmd (dpu_load_cmd),
    .requst_valid (requst_valid),
    .nxt_cmd      (nxt_cmd),
    .dpu_result   (dpu_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // dpu arithmetic by mode: ADD 1, SUB 1, DIV 2, MUL 2, all modulo 2^32
  function automatic logic [31:0] dpu_fn(input logic [1:0] m, input logic [31:0] x);
    case (m)
      2'b00:   return x + 32'd1;
      2'b01:   return x - 32'd1;
      2'b10:   return x >> 1;
      default: return x << 1;
    endcase
  endfunction

  // SRAM stand-in
  logic [31:0] mem [32];
  always @(posedge clk) begin
    if (sram_en && sram_we) mem[sram_addr] <= sram_wdata;
    if (sram_en && !sram_we) sram_rdata <= mem[sram_addr];
  end

  // dpu stand-in
  logic [1:0]  d_mode;
  logic [1:0]  d_phase;
  logic [31:0] d_opnd;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      d_mode <= 2'b00; d_phase <= 2'd0; d_opnd <= '0; dpu_result <= '0;
    end else if (dpu_load_cmd) begin
      d_mode <= nxt_cmd[6:5]; d_phase <= 2'd1;
    end else if (d_phase == 2'd1 && requst_valid) begin
      d_opnd <= sram_rdata; d_phase <= 2'd2;
    end else if (d_phase == 2'd2) begin
      dpu_result <= dpu_fn(d_mode, d_opnd); d_phase <= 2'd3;
    end else if (d_phase == 2'd3 && requst_valid) begin
      d_phase <= 2'd0;
    end
  end

  // Reference model and expectation queues
  logic [31:0] ref_mem [32];
  logic [4:0]  exp_wa [$];
  logic [31:0] exp_wd [$];
  logic [7:0]  exp_rb [$];
  bit          dpu_window = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (sram_en && sram_we) begin
        if (exp_wa.size() == 0) check("unexpected_write", 32'd1, 32'd0);
        else begin
          check("wr_addr", 32'(sram_addr), 32'(exp_wa.pop_front()));
          check("wr_data", sram_wdata, exp_wd.pop_front());
        end
      end
      if (h.dout_valid && h.dout_ready) begin
        if (exp_rb.size() == 0) check("unexpected_byte", 32'd1, 32'd0);
        else check("rd_byte", 32'(h.dout), 32'(exp_rb.pop_front()));
      end
      if ((dpu_load_cmd || requst_valid) && !dpu_window)
        check("dpu_strobe_outside", 32'd1, 32'd0);
    end
  end

  // All tasks start and end at posedge+1
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    h.cmd_valid = 1'b1;
    h.cmd_in    = b;
    @(negedge clk);
    while (!h.cmd_ready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) check("cmd_ready_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    h.cmd_valid = 1'b0;
    h.cmd_in    = 8'h00;
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] w, input int gap);
    exp_wa.push_back(a);
    exp_wd.push_back(w);
    ref_mem[a] = w;
    send_byte({3'b000, a});
    for (int i = 0; i < 4; i++) begin
      repeat (gap) begin @(posedge clk); #1; end
      send_byte(w[8*i +: 8]);
    end
    @(negedge clk);
    check("wr_strobe", 32'({sram_en, sram_we}), 32'd3);
    @(posedge clk); #1;
  endtask

  task automatic do_read(input logic [4:0] a, input int gap);
    logic [31:0] w;
    int n;
    w = ref_mem[a];
    for (int i = 0; i < 4; i++) exp_rb.push_back(w[8*i +: 8]);
    h.dout_ready = 1'b0;
    send_byte({3'b001, a});
    @(negedge clk);
    check("rd_c1_en", 32'({sram_en, sram_we}), 32'd2);
    check("rd_c1_addr", 32'(sram_addr), 32'(a));
    @(negedge clk);
    check("rd_c2_dout_valid", 32'(h.dout_valid), 32'd0);
    @(negedge clk);
    check("rd_c3_dout_valid", 32'(h.dout_valid), 32'd1);
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      h.dout_ready = 1'b0;
      repeat (gap) begin
        @(negedge clk);
        check("rd_hold_dout", 32'(h.dout), 32'(w[8*k +: 8]));
        check("rd_hold_busy", 32'({busy, h.dout_valid}), 32'd3);
        @(posedge clk); #1;
      end
      h.dout_ready = 1'b1;
      n = 0;
      @(negedge clk);
      while (!h.dout_valid && n < 50) begin @(negedge clk); n++; end
      if (n >= 50) check("dout_valid_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
    end
    h.dout_ready = 1'b0;
    @(negedge clk);
    check("rd_done_busy", 32'({busy, h.dout_valid, h.cmd_ready}), 32'b001);
    @(posedge clk); #1;
  endtask

  task automatic do_dpu(input logic [7:0] c);
    logic [4:0] a;
    a = c[4:0];
    exp_wa.push_back(a);
    exp_wd.push_back(dpu_fn(c[6:5], ref_mem[a]));
    ref_mem[a] = dpu_fn(c[6:5], ref_mem[a]);
    dpu_window = 1;
    send_byte(c);
    @(negedge clk);
    check("dpu_c1_strobes", 32'({dpu_load_cmd, requst_valid, sram_en, sram_we}), 32'b1010);
    check("dpu_c1_addr", 32'(sram_addr), 32'(a));
    check("dpu_c1_nxt_cmd", 32'(nxt_cmd), 32'(c));
    @(negedge clk);
    check("dpu_c2_strobes", 32'({dpu_load_cmd, requst_valid, sram_en, sram_we}), 32'b0100);
    @(negedge clk);
    check("dpu_c3_strobes", 32'({dpu_load_cmd, requst_valid, sram_en, sram_we}), 32'b0000);
    @(negedge clk);
    check("dpu_c4_strobes", 32'({dpu_load_cmd, requst_valid, sram_en, sram_we}), 32'b0111);
    @(negedge clk);
    check("dpu_c5_idle", 32'({busy, dpu_load_cmd, requst_valid, sram_en}), 32'b0000);
    dpu_window = 0;
    @(negedge clk);
    check("dpu_c6_cmd_ready", 32'(h.cmd_ready), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic check_outputs_zero(input string name);
    check(name, 32'({h.cmd_ready, h.dout_valid, busy, sram_en, sram_we, dpu_load_cmd, requst_valid}), 32'd0);
    check({name, "_buses"}, 32'({sram_addr, nxt_cmd, h.dout}), 32'd0);
    check({name, "_wdata"}, sram_wdata, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) begin mem[i] = '0; ref_mem[i] = '0; end
    rst = 1'b1;
    h.cmd_valid = 1'b0; h.cmd_in = 8'h00; h.dout_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    do_write(5'd3, 32'h12345678, 0);
    check("mem3_literal", mem[3], 32'h12345678);
    do_read(5'd3, 0);

    do_write(5'd5, 32'h00000010, 0);
    do_dpu(8'hC5);
    check("mem5_div_literal", mem[5], 32'h00000008);
    do_read(5'd5, 0);

    do_write(5'd0, 32'h00000000, 1);
    do_dpu(8'hA0);
    check("mem0_sub_literal", mem[0], 32'hFFFFFFFF);
    do_dpu(8'h80);
    check("mem0_add_literal", mem[0], 32'h00000000);

    do_write(5'd9, 32'hDEADBEEF, 2);
    do_read(5'd9, 5);
    do_dpu(8'hE9);
    check("mem9_shl_literal", mem[9], 32'hBD5B7DDE);
    do_read(5'd9, 1);

    // Reset in the middle of a write: partial word discarded
    send_byte(8'h03);
    send_byte(8'hAA);
    send_byte(8'hBB);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_outputs_zero("mid_write_reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    do_read(5'd3, 0);
    check("mem3_after_reset", mem[3], 32'h12345678);

    // Reserved command: consumed, nothing happens
    send_byte(8'h40);
    repeat (3) begin
      @(negedge clk);
      check("reserved_idle", 32'({h.cmd_ready, busy, sram_en, dpu_load_cmd, requst_valid}), 32'b10000);
    end
    @(posedge clk); #1;

    check("exp_writes_left", 32'(exp_wa.size()), 32'd0);
    check("exp_bytes_left", 32'(exp_rb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
